spi_mem_port: RTL and testbench
===============================

SPI_MEM_PORT -- requirements
Module: spi_mem_port

Interface
REQ-001 Parameter AW, default 8, memory address width in bits (1..16).
REQ-002 Parameter DW, default 8, memory data word width in bits (1..32).
REQ-003 Port clk, input, 1, single system clock; all logic on posedge clk.
REQ-004 Port reset_flag, input, 1, synchronous active-high reset; also used as per-transaction reset (chip-select deassert).
REQ-005 Port sel, input, 1, SPI chip select qualifier; rising/falling ignored when low.
REQ-006 Port rising, input, 1, one-clk strobe for an SCK rising edge; si sampled on it.
REQ-007 Port falling, input, 1, one-clk strobe for an SCK falling edge; so updated on it.
REQ-008 Port si, input, 1, serial data in, MSB first.
REQ-009 Port so, output, 1, serial data out, MSB first.
REQ-010 Port we, output, 1, one-clk write strobe to memory.
REQ-011 Port wr_data, output, DW, write data, valid while we=1.
REQ-012 Port rd_en, output, 1, one-clk read request to memory.
REQ-013 Port rd_data, input, DW, memory read data, valid exactly 1 clk after rd_en.
REQ-014 Port addr, output, AW, current memory address.
REQ-015 Port mode_wr, output, 1, high while the transaction is a write.

Function
REQ-016 Transaction framing: 8-bit command, then AW address bits, then an unbounded stream of DW-bit data words; all MSB first.
REQ-017 States: CMD, ADDR, WRITE, READ; bit counter counts rising strobes within the current field.
REQ-018 CMD: on the 8th rising, cmd bit7=1 selects write, 0 selects read; bits 6:0 ignored; go to ADDR.
REQ-019 ADDR: on the AW-th rising, addr loads the full shifted address (last bit included) on the next clk; go to WRITE or READ.
REQ-020 WRITE: on the DW-th rising of each word, next clk asserts we for exactly 1 clk with wr_data = received word and addr = word address.
REQ-021 WRITE: addr increments by 1 on the clk after we; counter restarts for the next word.
REQ-022 READ: rd_en asserted 1 clk after addr load at ADDR exit; rd_data loaded into the tx shift register 1 clk after rd_en.
REQ-023 READ: on the DW-th rising of each word, addr increments, then rd_en reissued at the new addr, same load latency.
REQ-024 so = tx register MSB; on falling, tx shifts left by one, except the first falling after a load, which only clears the fresh-load flag.
REQ-025 so SHALL be 0 in CMD, ADDR and WRITE states.
REQ-026 Address arithmetic modulo 2^AW: 2^AW-1 increments to 0, no flag, stream continues.
REQ-027 Timing contract: at least 4 clk between successive rising and falling strobes; the block need not handle closer spacing.
REQ-028 rising and falling never coincide; if they do, rising is processed and falling dropped.
REQ-029 sel=0: strobes ignored, state, counters and registers hold.
REQ-030 Partial word at reset_flag: discarded, no we, no addr change.

Reset
REQ-031 reset_flag=1 at any clk: state=CMD, bit counter=0, addr=0, we=0, rd_en=0, wr_data=0, tx register=0, so=0, mode_wr=0, fresh flag=0, on the next clk.
REQ-032 reset_flag has priority over every simultaneous event, including a completing word (no we/rd_en issued).

Verification
REQ-033 AW=8, DW=8: cmd 0x80, addr 0x10, data 0xA5,0x3C -> we pulses with (0x10,0xA5) then (0x11,0x3C); addr=0x12 after.
REQ-034 AW=8, DW=16: cmd 0x00, addr 0x20, memory model returns 0x1234 at 0x20, 0xBEEF at 0x21 -> so stream 0x1234 then 0xBEEF, rd_en at 0x20, 0x21, 0x22.
REQ-035 AW=4: write start addr 0xF, three words -> writes at 0xF, 0x0, 0x1.
REQ-036 reset_flag after 5 bits of a write data word -> no we, state CMD, addr=0; next transaction cmd 0x80 addr 0x05 data 0x77 -> single write (0x05,0x77).
REQ-037 sel=0 with rising/falling toggling mid-address -> no state change; resuming sel=1 completes address correctly.
REQ-038 reset_flag asserted on the clk the 8th data bit completes -> no we, all outputs at reset values.

Source files
------------

// File: rtl/spi_mem_port.sv
// spi_mem_port: SPI slave bridging a cmd/addr/data serial stream onto a simple memory port.
module spi_mem_port #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_flag,
  input  logic          sel,
  input  logic          rising,
  input  logic          falling,
  input  logic          si,
  output logic          so,
  output logic          we,
  output logic [DW-1:0] wr_data,
  output logic          rd_en,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] addr,
  output logic          mode_wr
);
  localparam int RW = (AW > DW ? AW : DW) > 8 ? (AW > DW ? AW : DW) : 8;
  typedef enum logic [1:0] {CMD, ADDR, WRITE, READ} state_t;
  state_t state, state_n;
  logic [5:0] cnt, len;
  logic [RW-2:0] rx;
  logic [RW-1:0] rx_n;
  logic [DW-1:0] tx;
  logic rise, fall, done, fresh, rd_req, rd_pend;
  assign rise = sel & rising;
  assign fall = sel & falling & ~rising;
  assign rx_n = {rx, si};
  assign so = (state == READ) & tx[DW-1];
  always_comb begin
    len = state == CMD ? 6'd8 : state == ADDR ? 6'(AW) : 6'(DW);
    done = rise && cnt == len - 6'd1;
    state_n = !done ? state : state == CMD ? ADDR : state == ADDR ? (mode_wr ? WRITE : READ) : state;
  end
  always_ff @(posedge clk)
    if (reset_flag) state <= CMD;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset_flag) begin
      cnt <= '0;
      rx <= '0;
      addr <= '0;
      we <= 1'b0;
      rd_en <= 1'b0;
      rd_req <= 1'b0;
      rd_pend <= 1'b0;
      wr_data <= '0;
      tx <= '0;
      fresh <= 1'b0;
      mode_wr <= 1'b0;
    end else begin
      we <= 1'b0;
      rd_req <= done && ((state == ADDR && !mode_wr) || state == READ);
      rd_en <= rd_req;
      rd_pend <= rd_en;
      if (rise) begin
        rx <= rx_n[RW-2:0];
        cnt <= done ? '0 : cnt + 6'd1;
      end
      if (done && state == CMD) mode_wr <= rx_n[7];
      if (done && state == ADDR) addr <= rx_n[AW-1:0];
      if ((done && state == READ) || we) addr <= addr + AW'(1);
      if (done && state == WRITE) begin
        we <= 1'b1;
        wr_data <= rx_n[DW-1:0];
      end
      // the first falling after a load keeps the MSB on so for the master's next rising
      if (rd_pend) begin
        tx <= rd_data;
        fresh <= 1'b1;
      end else if (fall && state == READ) begin
        if (fresh) fresh <= 1'b0;
        else tx <= tx << 1;
      end
    end
endmodule

// File: tb/tb_spi_mem_port.sv
// tb_spi_mem_port: directed vector bench driving three configurations of spi_mem_port from one serial stream.
module tb_spi_mem_port;
  logic clk = 0, reset_flag = 0, sel = 0, rising = 0, falling = 0, si = 0;
  always #5 clk = ~clk;
  logic so0, we0, rd_en0, mode_wr0;
  logic [7:0] wr_data0, addr0;
  logic [7:0] rd_data0 = '0;
  logic so1, we1, rd_en1, mode_wr1;
  logic [15:0] wr_data1;
  logic [15:0] rd_data1 = '0;
  logic [7:0] addr1;
  logic so2, we2, rd_en2, mode_wr2;
  logic [7:0] wr_data2;
  logic [7:0] rd_data2 = '0;
  logic [3:0] addr2;
  spi_mem_port #(.AW(8), .DW(8)) u0 (.clk(clk), .reset_flag(reset_flag), .sel(sel), .rising(rising),
    .falling(falling), .si(si), .so(so0), .we(we0), .wr_data(wr_data0), .rd_en(rd_en0),
    .rd_data(rd_data0), .addr(addr0), .mode_wr(mode_wr0));
  spi_mem_port #(.AW(8), .DW(16)) u1 (.clk(clk), .reset_flag(reset_flag), .sel(sel), .rising(rising),
    .falling(falling), .si(si), .so(so1), .we(we1), .wr_data(wr_data1), .rd_en(rd_en1),
    .rd_data(rd_data1), .addr(addr1), .mode_wr(mode_wr1));
  spi_mem_port #(.AW(4), .DW(8)) u2 (.clk(clk), .reset_flag(reset_flag), .sel(sel), .rising(rising),
    .falling(falling), .si(si), .so(so2), .we(we2), .wr_data(wr_data2), .rd_en(rd_en2),
    .rd_data(rd_data2), .addr(addr2), .mode_wr(mode_wr2));
  logic [15:0] mem1 [256];
  logic [55:0] wq [$];
  logic [7:0] rq [$];
  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= mem1[addr1];
    if (rd_en1) rq.push_back(addr1);
    if (we0) wq.push_back({8'd0, 8'd0, addr0, 24'd0, wr_data0});
    if (we1) wq.push_back({8'd1, 8'd0, addr1, 16'd0, wr_data1});
    if (we2) wq.push_back({8'd2, 12'd0, addr2, 24'd0, wr_data2});
  end
  int n_chk = 0, n_bad = 0;
  logic [31:0] so_word;
  logic so_or;
  typedef struct {
    int u;
    logic [7:0] cmd;
    logic [15:0] a;
    int n;
    logic [2:0][31:0] d;
    logic [2:0][15:0] e;
    logic [15:0] ef;
  } vec_t;
  vec_t tv [5];
  function automatic vec_t mk(int u, logic [7:0] cmd, logic [15:0] a, int n, logic [31:0] d0, logic [31:0] d1,
                              logic [31:0] d2, logic [15:0] e0, logic [15:0] e1, logic [15:0] e2, logic [15:0] ef);
    vec_t v;
    v.u = u; v.cmd = cmd; v.a = a; v.n = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
    v.ef = ef;
    return v;
  endfunction
  function automatic logic so_of(int u);
    return u == 0 ? so0 : u == 1 ? so1 : so2;
  endfunction
  function automatic logic mode_of(int u);
    return u == 0 ? mode_wr0 : u == 1 ? mode_wr1 : mode_wr2;
  endfunction
  function automatic logic [15:0] addr_of(int u);
    return u == 0 ? 16'(addr0) : u == 1 ? 16'(addr1) : 16'(addr2);
  endfunction
  function automatic int aw_of(int u);
    return u == 2 ? 4 : 8;
  endfunction
  function automatic int dw_of(int u);
    return u == 1 ? 16 : 8;
  endfunction
  function automatic int we_cnt(int u);
    int c = 0;
    for (int j = 0; j < wq.size(); j++) if (wq[j][55:48] == 8'(u)) c++;
    return c;
  endfunction
  function automatic logic [47:0] we_nth(int u, int idx);
    int c = 0;
    for (int j = 0; j < wq.size(); j++)
      if (wq[j][55:48] == 8'(u)) begin
        if (c == idx) return wq[j][47:0];
        c++;
      end
    return '1;
  endfunction
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic sbit(int u, logic b, logic rst_too = 1'b0);
    si = b;
    so_word = {so_word[30:0], so_of(u)};
    so_or = so_or | so_of(u);
    rising = 1; reset_flag = rst_too;
    tick();
    rising = 0; reset_flag = 0;
    tick(4);
    falling = 1;
    tick();
    falling = 0;
    tick(4);
  endtask
  task automatic send(int u, logic [31:0] v, int nb);
    for (int i = nb - 1; i >= 0; i--) sbit(u, v[i]);
  endtask
  task automatic rst_all();
    sel = 0;
    reset_flag = 1;
    tick();
    reset_flag = 0;
    tick();
    wq.delete();
    rq.delete();
  endtask
  initial begin
    vec_t v;
    logic [31:0] mask;
    tv[0] = mk(0, 8'h80, 16'h10, 2, 32'hA5, 32'h3C, 0, 16'h10, 16'h11, 0, 16'h12);
    tv[1] = mk(2, 8'h80, 16'hF, 3, 32'h11, 32'h22, 32'h33, 16'hF, 16'h0, 16'h1, 16'h2);
    tv[2] = mk(0, 8'hFF, 16'hFF, 2, 32'h01, 32'h80, 0, 16'hFF, 16'h00, 0, 16'h01);
    tv[3] = mk(1, 8'h00, 16'h20, 2, 32'h1234, 32'hBEEF, 0, 16'h20, 16'h21, 0, 16'h22);
    tv[4] = mk(1, 8'h7F, 16'hFF, 2, 32'hA55A, 32'h0001, 0, 16'hFF, 16'h00, 0, 16'h01);
    tick();
    rst_all();
    chk("reset_u0", {so0, we0, rd_en0, mode_wr0, wr_data0, addr0}, 0);
    chk("reset_u1", {so1, we1, rd_en1, mode_wr1, wr_data1, addr1}, 0);
    chk("reset_u2", {so2, we2, rd_en2, mode_wr2, wr_data2, addr2}, 0);
    for (int k = 0; k < 5; k++) begin
      rst_all();
      v = tv[k];
      mask = 32'((64'd1 << dw_of(v.u)) - 1);
      for (int i = 0; i < v.n; i++) mem1[v.e[i][7:0]] = v.d[i][15:0];
      sel = 1; so_or = 0;
      send(v.u, 32'(v.cmd), 8);
      chk($sformatf("v%0d_mode", k), mode_of(v.u), v.cmd[7]);
      send(v.u, 32'(v.a), aw_of(v.u));
      chk($sformatf("v%0d_so_idle", k), so_or, 0);
      for (int i = 0; i < v.n; i++) begin
        so_word = 0;
        send(v.u, v.cmd[7] ? v.d[i] : 32'd0, dw_of(v.u));
        if (!v.cmd[7]) chk($sformatf("v%0d_so_word%0d", k, i), so_word & mask, v.d[i]);
      end
      tick(10);
      chk($sformatf("v%0d_we_count", k), we_cnt(v.u), v.cmd[7] ? v.n : 0);
      if (v.cmd[7]) begin
        chk($sformatf("v%0d_so_write", k), so_or, 0);
        for (int i = 0; i < v.n; i++) chk($sformatf("v%0d_we%0d", k, i), we_nth(v.u, i), {v.e[i], v.d[i]});
      end else begin
        chk($sformatf("v%0d_rd_count", k), rq.size(), v.n + 1);
        for (int i = 0; i < v.n; i++) chk($sformatf("v%0d_rd%0d", k, i), rq[i], v.e[i][7:0]);
        chk($sformatf("v%0d_rd_last", k), rq[v.n], v.ef[7:0]);
      end
      chk($sformatf("v%0d_final_addr", k), addr_of(v.u), v.ef);
    end
    rst_all();
    sel = 1;
    send(0, 32'h80, 8);
    send(0, 32'h33, 8);
    send(0, 32'h1F, 5);
    reset_flag = 1;
    tick();
    reset_flag = 0;
    tick(3);
    chk("partial_no_we", we_cnt(0), 0);
    chk("partial_state", {mode_wr0, addr0}, 0);
    send(0, 32'h80, 8);
    send(0, 32'h05, 8);
    send(0, 32'h77, 8);
    tick(10);
    chk("after_partial_count", we_cnt(0), 1);
    chk("after_partial_we", we_nth(0, 0), {16'h05, 32'h77});
    chk("after_partial_addr", addr0, 8'h06);
    rst_all();
    sel = 1;
    send(0, 32'h80, 8);
    send(0, 32'hC, 4);
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      si = ~si;
      rising = 1; tick(); rising = 0; tick(4);
      falling = 1; tick(); falling = 0; tick(4);
    end
    chk("sel_low_addr", addr0, 8'h00);
    sel = 1;
    send(0, 32'h3, 4);
    send(0, 32'h5A, 8);
    tick(10);
    chk("sel_resume_count", we_cnt(0), 1);
    chk("sel_resume_we", we_nth(0, 0), {16'hC3, 32'h5A});
    chk("sel_resume_addr", addr0, 8'hC4);
    rst_all();
    sel = 1;
    send(0, 32'h80, 8);
    send(0, 32'h40, 8);
    send(0, 32'h99, 8);
    send(0, 32'h33, 7);
    sbit(0, 1'b0, 1'b1);
    tick(5);
    chk("rst_done_count", we_cnt(0), 1);
    chk("rst_done_we", we_nth(0, 0), {16'h40, 32'h99});
    chk("rst_done_outputs", {so0, we0, rd_en0, mode_wr0, wr_data0, addr0}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
